// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA receive path: timing totals, lock FSM
// states and the CRC-16-CCITT step used for frame signatures.
package vga_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  function automatic logic [COORD_W-1:0] timing_total(input int a, input int b,
                                                      input int c, input int d);
    return COORD_W'(a + b + c + d);
  endfunction

  // CRC-16-CCITT (poly 0x1021), one 16-bit word shifted in MSB first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync pin and flags the cycle where it becomes active.
module vga_sync_edge #(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead
);

  logic s_q, s_p;

  // Samples reset to the inactive level so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= ~ACTIVE;
      s_p <= ~ACTIVE;
    end else begin
      s_q <= sync_in;
      s_p <= s_q;
    end
  end

  assign lead = (s_q == ACTIVE) && (s_p != ACTIVE);

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: recovers x/y from HSYNC/VSYNC, verifies line/frame periods and
// emits a pixel stream once locked. Define VGA_RX_CRC_EN for a per-frame CRC.
module vga_rx
  import vga_pkg::*;
#(
  parameter int   H_PIXELS     = 640,
  parameter int   H_FRONTPORCH = 16,
  parameter int   H_SYNCTIME   = 96,
  parameter int   H_BACKPORCH  = 48,
  parameter int   V_LINES      = 480,
  parameter int   V_FRONTPORCH = 10,
  parameter int   V_SYNCTIME   = 2,
  parameter int   V_BACKPORCH  = 33,
  parameter logic SYNC_ACTIVE  = 1'b0
) (
  input  logic               clk_pll,
  input  logic               rst,
  input  logic               HSYNC,
  input  logic               VSYNC,
  input  logic [4:0]         RED_IN,
  input  logic [5:0]         GREEN_IN,
  input  logic [4:0]         BLUE_IN,
  output logic               locked,
  output logic               px_valid,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [15:0]        px_rgb,
  output logic               frame_start,
  output logic               h_err,
  output logic               v_err,
  output logic [COORD_W-1:0] line_len,
  output logic [COORD_W-1:0] frame_lines,
  output logic [15:0]        frame_crc
);

  localparam logic [COORD_W-1:0] H_TOTAL = timing_total(H_PIXELS, H_FRONTPORCH, H_SYNCTIME, H_BACKPORCH);
  localparam logic [COORD_W-1:0] V_TOTAL = timing_total(V_LINES, V_FRONTPORCH, V_SYNCTIME, V_BACKPORCH);
  localparam logic [COORD_W-1:0] H_LO    = COORD_W'(H_SYNCTIME + H_BACKPORCH);
  localparam logic [COORD_W-1:0] H_HI    = COORD_W'(H_SYNCTIME + H_BACKPORCH + H_PIXELS);
  localparam logic [COORD_W-1:0] V_LO    = COORD_W'(V_SYNCTIME + V_BACKPORCH);
  localparam logic [COORD_W-1:0] V_HI    = COORD_W'(V_SYNCTIME + V_BACKPORCH + V_LINES);
  localparam logic [COORD_W-1:0] CNT_MAX = '1;

  logic [1:0] sync_pins, sync_lead;
  logic       h_lead, v_lead;

  assign sync_pins = {VSYNC, HSYNC};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_edge (
      .clk     (clk_pll),
      .rst     (rst),
      .sync_in (sync_pins[i]),
      .lead    (sync_lead[i])
    );
  end

  assign h_lead = sync_lead[0];
  assign v_lead = sync_lead[1];

  logic [15:0] rgb_q;

  always_ff @(posedge clk_pll) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= {RED_IN, GREEN_IN, BLUE_IN};
  end

  rx_state_e          state, state_nxt;
  logic [COORD_W-1:0] h_cnt, v_cnt, h_cur, v_cur, h_len, v_len;
  logic               armed, h_sat, h_bad, v_bad, pix_nxt;

  // h_cur/v_cur are the coordinates of the sample currently in rgb_q.
  always_comb begin
    h_cur = h_cnt;
    if (h_lead)                h_cur = '0;
    else if (h_cnt != CNT_MAX) h_cur = h_cnt + 12'd1;
    v_cur = v_cnt;
    if (v_lead)                          v_cur = '0;
    else if (h_lead && v_cnt != CNT_MAX) v_cur = v_cnt + 12'd1;
  end

  assign h_len = h_cnt + 12'd1;
  assign v_len = v_cnt + 12'd1;
  assign h_sat = !h_lead && (h_cnt == CNT_MAX - 12'd1);

  // No checks while searching; the first line after acquisition may be partial.
  assign h_bad = (state != SEARCH) && ((h_lead && armed && h_len != H_TOTAL) || h_sat);
  assign v_bad = (state != SEARCH) && v_lead && (v_len != V_TOTAL);

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (v_lead) state_nxt = MEASURE;
      MEASURE: if (h_bad || v_bad) state_nxt = SEARCH;
               else if (v_lead)    state_nxt = LOCKED;
      LOCKED:  if (h_bad || v_bad) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  assign pix_nxt = (state_nxt == LOCKED) && (h_cur >= H_LO) && (h_cur < H_HI)
                && (v_cur >= V_LO) && (v_cur < V_HI);
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      state <= SEARCH;
      h_cnt <= '0;
      v_cnt <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_cur;
      v_cnt <= v_cur;
      armed <= (state != SEARCH) && (armed || h_lead);
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      px_valid    <= pix_nxt;
      frame_start <= pix_nxt && (h_cur == H_LO) && (v_cur == V_LO);
      h_err       <= h_bad;
      v_err       <= v_bad;
      if (pix_nxt) begin
        px_x   <= h_cur - H_LO;
        px_y   <= v_cur - V_LO;
        px_rgb <= rgb_q;
      end
      if (h_lead) line_len    <= h_len;
      if (v_lead) frame_lines <= v_len;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q, crc_nx;

  assign crc_nx = crc16_next(frame_start ? 16'hFFFF : crc_q, px_rgb);

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      crc_q     <= '0;
      frame_crc <= '0;
    end else if (px_valid) begin
      crc_q <= crc_nx;
      if (px_x == COORD_W'(H_PIXELS - 1) && px_y == COORD_W'(V_LINES - 1))
        frame_crc <= crc_nx;
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule
